// File: rtl/in1_conditioner_pkg.sv
// Shared constants for the In1 input conditioner: FSM state encoding,
// default synchronizer/debounce parameters and the glitch counter width.
package in1_conditioner_pkg;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int GLITCH_W            = 8;

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    PEND_HI   = 2'b01,
    STABLE_HI = 2'b11,
    PEND_LO   = 2'b10
  } state_t;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [GLITCH_W-1:0] glitch_sat_inc(input logic [GLITCH_W-1:0] v);
    logic [GLITCH_W-1:0] r;
    if (v == {GLITCH_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(GLITCH_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for a single asynchronous level; the last stage
// is the only safe sample point for downstream logic.
module sync_chain #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sync_q;
  logic [DEPTH-1:0] sync_d;

  // Shift the raw level one stage deeper every cycle.
  always_comb begin
    sync_d = {sync_q[DEPTH-2:0], d};
  end

  // Chain registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {DEPTH{1'b0}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[DEPTH-1];

endmodule

// File: rtl/in1_conditioner.sv
// Synchronizes and debounces RAW_IN into the registered level In1, with
// edge pulses and a saturating count of rejected transitions.
module in1_conditioner
  import in1_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                RAW_IN,
  input  logic                EN,
  output logic                In1,
  output logic                RISE,
  output logic                FALL,
  output logic [GLITCH_W-1:0] GLITCH_CNT
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic                s_sync;
  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                in1_q, in1_d;
  logic                rise_q, rise_d;
  logic                fall_q, fall_d;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;

  sync_chain #(
    .DEPTH (SYNC_STAGES)
  ) u_sync (
    .clk   (CLK),
    .rst_n (RST),
    .d     (RAW_IN),
    .q     (s_sync)
  );

  // Debounce FSM: next state, counter and output register values.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    in1_d    = in1_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    glitch_d = glitch_q;
    case (state_q)
      STABLE_LO: begin
        in1_d = 1'b0;
        if (s_sync && EN) begin
          state_d = PEND_HI;
          cnt_d   = CNT_ONE;
        end else begin
          state_d = STABLE_LO;
          cnt_d   = CNT_ZERO;
        end
      end
      PEND_HI: begin
        if (!EN) begin
          state_d = STABLE_LO;
          cnt_d   = CNT_ZERO;
        end else if (!s_sync) begin
          state_d  = STABLE_LO;
          cnt_d    = CNT_ZERO;
          glitch_d = glitch_sat_inc(glitch_q);
        end else if (cnt_q >= CNT_MAX) begin
          state_d = STABLE_HI;
          cnt_d   = CNT_ZERO;
          in1_d   = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STABLE_HI: begin
        in1_d = 1'b1;
        if (!s_sync && EN) begin
          state_d = PEND_LO;
          cnt_d   = CNT_ONE;
        end else begin
          state_d = STABLE_HI;
          cnt_d   = CNT_ZERO;
        end
      end
      PEND_LO: begin
        if (!EN) begin
          state_d = STABLE_HI;
          cnt_d   = CNT_ZERO;
        end else if (s_sync) begin
          state_d  = STABLE_HI;
          cnt_d    = CNT_ZERO;
          glitch_d = glitch_sat_inc(glitch_q);
        end else if (cnt_q >= CNT_MAX) begin
          state_d = STABLE_LO;
          cnt_d   = CNT_ZERO;
          in1_d   = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = CNT_ZERO;
        in1_d   = 1'b0;
      end
    endcase
  end

  // State, counter and output registers; reset discards any pending edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= STABLE_LO;
      cnt_q    <= CNT_ZERO;
      in1_q    <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= {GLITCH_W{1'b0}};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      in1_q    <= in1_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
    end
  end

  assign In1        = in1_q;
  assign RISE       = rise_q;
  assign FALL       = fall_q;
  assign GLITCH_CNT = glitch_q;

endmodule

// File: tb/tb_in1_conditioner.sv
// Scoreboard bench for in1_conditioner: stimulus queues expected edge events
// and level/count checkpoints; a negedge monitor pops and compares them.
module tb_in1_conditioner;

  logic       CLK;
  logic       RST;
  logic       RAW_IN;
  logic       EN;
  logic       In1;
  logic       RISE;
  logic       FALL;
  logic [7:0] GLITCH_CNT;

  in1_conditioner dut (
    .CLK        (CLK),
    .RST        (RST),
    .RAW_IN     (RAW_IN),
    .EN         (EN),
    .In1        (In1),
    .RISE       (RISE),
    .FALL       (FALL),
    .GLITCH_CNT (GLITCH_CNT)
  );

  typedef struct {int kind; int cyc;} evt_t;          // kind 1 = RISE, 2 = FALL
  typedef struct {int cyc; int in1; int gc;} chk_t;

  evt_t evq[$];
  chk_t chq[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  logic prev_in1 = 1'b0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic push_evt(input int kind, input int c);
    evt_t e;
    e.kind = kind;
    e.cyc  = c;
    evq.push_back(e);
  endtask

  task automatic push_chk(input int c, input int in1, input int gc);
    chk_t k;
    k.cyc = c;
    k.in1 = in1;
    k.gc  = gc;
    chq.push_back(k);
  endtask

  // Monitor: compares every observed edge pulse and any due checkpoint.
  always @(negedge CLK) begin
    evt_t e;
    chk_t k;
    if (RISE === 1'b1 || FALL === 1'b1) begin
      check("rise_fall_exclusive", {31'd0, RISE & FALL}, 32'd0);
      if (evq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_edge at cycle %0d: RISE=%b FALL=%b, expected none", cyc, RISE, FALL);
      end else begin
        e = evq.pop_front();
        check("edge_kind", RISE ? 32'd1 : 32'd2, e.kind);
        check("edge_cycle", cyc, e.cyc);
        check("edge_level", {31'd0, In1}, RISE ? 32'd1 : 32'd0);
      end
    end else if (In1 !== prev_in1 && RST === 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL silent_level_change at cycle %0d: In1=%b without RISE/FALL", cyc, In1);
    end
    prev_in1 = In1;
    if (chq.size() > 0 && chq[0].cyc == cyc) begin
      k = chq.pop_front();
      check("in1_level", {31'd0, In1}, k.in1);
      check("glitch_cnt", {24'd0, GLITCH_CNT}, k.gc);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    RST = 1'b0;
    EN = 1'b1;
    RAW_IN = 1'b0;
    step(3);
    push_chk(cyc, 0, 0);
    step(1);
    RST = 1'b1;
    step(4);

    // Clean step up and back down: 7-edge latency each way.
    t0 = cyc;
    RAW_IN = 1'b1;
    push_evt(1, t0 + 7);
    push_chk(t0 + 6, 0, 0);
    push_chk(t0 + 7, 1, 0);
    step(12);
    t0 = cyc;
    RAW_IN = 1'b0;
    push_evt(2, t0 + 7);
    push_chk(t0 + 6, 1, 0);
    push_chk(t0 + 7, 0, 0);
    step(12);

    // Bounce 3 high, 2 low, 4 high, then low: two rejections.
    RAW_IN = 1'b1; step(3);
    RAW_IN = 1'b0; step(2);
    RAW_IN = 1'b1; step(4);
    RAW_IN = 1'b0; step(10);
    push_chk(cyc, 0, 2);
    step(1);

    // Threshold: 4-cycle pulse rejected, 5-cycle pulse accepted then released.
    RAW_IN = 1'b1; step(4);
    RAW_IN = 1'b0; step(8);
    t0 = cyc;
    RAW_IN = 1'b1;
    push_evt(1, t0 + 7);
    push_chk(t0 + 7, 1, 3);
    push_evt(2, t0 + 12);
    push_chk(t0 + 12, 0, 3);
    step(5);
    RAW_IN = 1'b0;
    step(12);

    // EN drop two cycles into PEND_HI: no rise, no glitch.
    RAW_IN = 1'b1;
    step(4);
    EN = 1'b0;
    RAW_IN = 1'b0;
    push_chk(cyc + 3, 0, 3);
    step(6);
    EN = 1'b1;
    step(2);
    EN = 1'b0;
    RAW_IN = 1'b1;
    step(15);
    push_chk(cyc, 0, 3);
    RAW_IN = 1'b0;
    step(6);
    EN = 1'b1;
    step(3);

    // Saturation: 300 rejected 2-cycle pulses from a count of 3.
    for (int i = 1; i <= 300; i++) begin
      RAW_IN = 1'b1; step(2);
      RAW_IN = 1'b0; step(3);
      if (i == 100) push_chk(cyc, 0, 103);
      if (i == 252) push_chk(cyc, 0, 255);
      if (i == 253) push_chk(cyc, 0, 255);
      if (i == 300) push_chk(cyc, 0, 255);
    end
    step(4);

    // Reset during PEND_LO, then release with RAW_IN held high.
    t0 = cyc;
    RAW_IN = 1'b1;
    push_evt(1, t0 + 7);
    push_chk(t0 + 7, 1, 255);
    step(10);
    RAW_IN = 1'b0;
    step(4);
    RST = 1'b0;
    RAW_IN = 1'b1;
    push_chk(cyc, 0, 0);
    step(1);
    RST = 1'b1;
    t0 = cyc;
    push_evt(1, t0 + 7);
    push_chk(t0 + 6, 0, 0);
    push_chk(t0 + 7, 1, 0);
    step(14);

    check("pending_edges_left", evq.size(), 32'd0);
    check("pending_checkpoints_left", chq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
